// File: rtl/io_pkg.sv
// io_pkg: address map and bus FSM encoding shared by the MMIO port files.
package io_pkg;
    localparam logic [1:0] IO_ADDR_DISPLAY = 2'd0;
    localparam logic [1:0] IO_ADDR_SWITCH  = 2'd1;
    localparam logic [1:0] IO_ADDR_BUTTON  = 2'd2;
    localparam int         BTN_EDGE_LSB    = 16;
    typedef enum logic {BUS_IDLE = 1'b0, BUS_ACK = 1'b1} bus_state_e;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-FF synchroniser plus per-bit stability counter.
module io_debounce
    import io_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] deb_o
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]         meta_q, sync_q, deb_q, deb_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced value disagrees with the accepted one.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (sync_q[b] != deb_q[b]) begin
                if (cnt_q[b] == CNT_MAX) deb_d[b] = sync_q[b];
                else cnt_d[b] = cnt_q[b] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
            deb_q  <= '0;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign deb_o = deb_q;
endmodule

// File: rtl/io_mmio_port.sv
// io_mmio_port: bus-mapped display register, debounced switches/buttons and
// sticky button-press flags with a level IRQ.
module io_mmio_port
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_SW          = 8,
    parameter int NUM_BTN         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_req,
    input  logic               bus_we,
    input  logic [1:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    input  logic [3:0]         bus_wstrb,
    output logic [31:0]        bus_rdata,
    output logic               bus_ack,
    input  logic [NUM_SW-1:0]  sw_in,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [31:0]        disp_num,
    output logic               btn_irq
);
    bus_state_e         state_q, state_d;
    logic [31:0]        disp_q, disp_d, rdata_q, rdata_d, btn_word;
    logic [NUM_SW-1:0]  sw_deb;
    logic [NUM_BTN-1:0] btn_deb, btn_prev_q, flags_q, flags_d, clr;
    logic               irq_q, take, wr;

    io_debounce #(.WIDTH(NUM_SW), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk(clk), .rst(rst), .raw_i(sw_in), .deb_o(sw_deb)
    );

    io_debounce #(.WIDTH(NUM_BTN), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk(clk), .rst(rst), .raw_i(btn_in), .deb_o(btn_deb)
    );

    always_comb begin
        take     = state_q == BUS_IDLE && bus_req;
        wr       = take && bus_we;
        state_d  = take ? BUS_ACK : BUS_IDLE;
        btn_word = '0;
        btn_word[NUM_BTN-1:0] = btn_deb;
        btn_word[BTN_EDGE_LSB +: NUM_BTN] = flags_q;
        disp_d = disp_q;
        for (int i = 0; i < 4; i++)
            if (wr && bus_addr == IO_ADDR_DISPLAY && bus_wstrb[i]) disp_d[8*i +: 8] = bus_wdata[8*i +: 8];
        clr = '0;
        for (int i = 0; i < NUM_BTN; i++)
            clr[i] = wr && bus_addr == IO_ADDR_BUTTON && bus_wstrb[(BTN_EDGE_LSB + i) / 8]
                     && bus_wdata[BTN_EDGE_LSB + i];
        // Applying the new edges after the clear lets a same-cycle press win.
        flags_d = (flags_q & ~clr) | (btn_deb & ~btn_prev_q);
        rdata_d = !take                       ? rdata_q :
                  bus_addr == IO_ADDR_DISPLAY ? disp_q :
                  bus_addr == IO_ADDR_SWITCH  ? 32'(sw_deb) :
                  bus_addr == IO_ADDR_BUTTON  ? btn_word : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BUS_IDLE;
            disp_q     <= '0;
            rdata_q    <= '0;
            btn_prev_q <= '0;
            flags_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            disp_q     <= disp_d;
            rdata_q    <= rdata_d;
            btn_prev_q <= btn_deb;
            flags_q    <= flags_d;
            irq_q      <= |flags_q;
        end
    end

    assign bus_ack   = state_q == BUS_ACK;
    assign bus_rdata = bus_ack ? rdata_q : '0;
    assign disp_num  = disp_q;
    assign btn_irq   = irq_q;
endmodule

// File: tb/tb_io_mmio_port.sv
// tb_io_mmio_port: scoreboard bench for io_mmio_port with DEBOUNCE_CYCLES=4.
module tb_io_mmio_port;
    logic        clk = 1'b0, rst = 1'b0, bus_req = 1'b0, bus_we = 1'b0, bus_ack, btn_irq;
    logic [1:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0, bus_rdata, disp_num;
    logic [3:0]  bus_wstrb = '0;
    logic [7:0]  sw_in = '0;
    logic [3:0]  btn_in = '0;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_q[$];

    io_mmio_port #(.DEBOUNCE_CYCLES(4), .NUM_SW(8), .NUM_BTN(4)) dut (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .sw_in(sw_in), .btn_in(btn_in), .disp_num(disp_num), .btn_irq(btn_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns on the negedge inside the ACK cycle with req already dropped.
    task automatic bus(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] exp);
        int n;
        logic [31:0] e;
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd; bus_wstrb = st;
        if (!we) exp_q.push_back(exp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_ack && n < 8);
        check("ack_latency", n, 1);
        if (!we && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus_ack) check($sformatf("rdata_a%0d", addr), bus_rdata, e);
        end
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_disp", disp_num, 0);
        check("rst_ack", {31'b0, bus_ack}, 0);
        check("rst_rdata", bus_rdata, 0);
        check("rst_irq", {31'b0, btn_irq}, 0);
        rst = 1'b1;

        bus(1'b1, 2'd0, 32'hDEADBEEF, 4'hF, '0);
        check("disp_full", disp_num, 32'hDEADBEEF);
        bus(1'b0, 2'd0, '0, '0, 32'hDEADBEEF);
        @(negedge clk);
        check("rdata_after_ack", bus_rdata, 0);
        check("ack_after", {31'b0, bus_ack}, 0);
        bus(1'b1, 2'd0, 32'h12345678, 4'b0101, '0);
        check("disp_strb", disp_num, 32'hDE34BE78);

        @(negedge clk);
        sw_in = 8'hA5;
        repeat (3) @(negedge clk);
        bus(1'b0, 2'd1, '0, '0, 32'h0);
        bus(1'b0, 2'd1, '0, '0, 32'h000000A5);
        @(negedge clk);
        sw_in = 8'hFF;
        repeat (2) @(negedge clk);
        sw_in = 8'hA5;
        repeat (8) @(negedge clk);
        bus(1'b0, 2'd1, '0, '0, 32'h000000A5);
        bus(1'b1, 2'd1, 32'hFFFFFFFF, 4'hF, '0);
        check("sw_write_ignored", disp_num, 32'hDE34BE78);
        bus(1'b0, 2'd1, '0, '0, 32'h000000A5);

        @(negedge clk);
        btn_in = 4'h4;
        repeat (10) @(negedge clk);
        btn_in = 4'h0;
        repeat (10) @(negedge clk);
        check("irq_set", {31'b0, btn_irq}, 1);
        bus(1'b0, 2'd2, '0, '0, 32'h00040000);
        bus(1'b0, 2'd2, '0, '0, 32'h00040000);
        bus(1'b1, 2'd2, 32'h00040000, 4'hF, '0);
        check("irq_hold", {31'b0, btn_irq}, 1);
        @(negedge clk);
        check("irq_clr", {31'b0, btn_irq}, 0);
        bus(1'b0, 2'd2, '0, '0, 32'h0);

        @(negedge clk);
        btn_in = 4'h4;
        repeat (5) @(negedge clk);
        bus(1'b1, 2'd2, 32'h00040000, 4'hF, '0);
        bus(1'b0, 2'd2, '0, '0, 32'h00040004);
        check("irq_set_wins", {31'b0, btn_irq}, 1);
        btn_in = 4'h0;
        repeat (10) @(negedge clk);
        bus(1'b1, 2'd2, 32'h00040000, 4'hF, '0);

        bus(1'b1, 2'd3, 32'hFFFFFFFF, 4'hF, '0);
        check("a3_write_ignored", disp_num, 32'hDE34BE78);
        bus(1'b0, 2'd3, '0, '0, 32'h0);

        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 2'd0; bus_wdata = 32'hCAFEF00D; bus_wstrb = 4'hF;
        @(negedge clk);
        check("pre_rst_ack", {31'b0, bus_ack}, 1);
        check("pre_rst_disp", disp_num, 32'hCAFEF00D);
        rst = 1'b0;
        #1;
        check("mid_rst_ack", {31'b0, bus_ack}, 0);
        check("mid_rst_disp", disp_num, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ack", {31'b0, bus_ack}, 1);
        check("post_rst_disp", disp_num, 32'hCAFEF00D);
        bus_req = 1'b0; bus_we = 1'b0;
        @(negedge clk);
        check("post_rst_single", {31'b0, bus_ack}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
